// File: rtl/ahb_lite_node.sv
// ahb_lite_node: single-master to NB_SLAVES AHB-Lite decoder/multiplexer.
// The address phase is decoded against run-time inclusive START/END ranges.
// The data-phase owner is registered so that responses come from the slave
// that accepted the address. Unmapped NONSEQ/SEQ accesses get a two-cycle
// ERROR from a built-in default slave.
// Optional feature: define AHB_LITE_NODE_TIMEOUT_EN to enable a data-phase
// watchdog. It aborts a slave that stalls for TIMEOUT_CYCLES-1 wait cycles.
module ahb_lite_node #(
    parameter int NB_SLAVES      = 8,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 hclk_i,
    input  logic                                 hrst_i,
    // master side
    input  logic [AHB_ADDR_WIDTH-1:0]            hadrr_i,
    input  logic [AHB_DATA_WIDTH-1:0]            hwdata_i,
    input  logic                                 hsel_i,
    input  logic                                 hwrite_i,
    input  logic                                 hmastlock_i,
    input  logic [1:0]                           htrans_i,
    input  logic [3:0]                           hprot_i,
    input  logic [2:0]                           hburst_i,
    input  logic [2:0]                           hsize_i,
    output logic                                 hresp_o,
    output logic                                 hreadyout_o,
    output logic [AHB_DATA_WIDTH-1:0]            hrdata_o,
    // slave side
    output logic [NB_SLAVES*AHB_ADDR_WIDTH-1:0]  hadrr_o,
    output logic [NB_SLAVES*AHB_DATA_WIDTH-1:0]  hwdata_o,
    output logic [NB_SLAVES-1:0]                 hsel_o,
    output logic [NB_SLAVES-1:0]                 hwrite_o,
    output logic [NB_SLAVES-1:0]                 hmastlock_o,
    output logic [NB_SLAVES-1:0]                 hready_o,
    output logic [NB_SLAVES*2-1:0]               htrans_o,
    output logic [NB_SLAVES*4-1:0]               hprot_o,
    output logic [NB_SLAVES*3-1:0]               hburst_o,
    output logic [NB_SLAVES*3-1:0]               hsize_o,
    input  logic [NB_SLAVES-1:0]                 hresp_i,
    input  logic [NB_SLAVES-1:0]                 hreadyout_i,
    input  logic [NB_SLAVES*AHB_DATA_WIDTH-1:0]  hrdata_i,
    // address map
    input  logic [NB_SLAVES*AHB_ADDR_WIDTH-1:0]  START_ADDR_i,
    input  logic [NB_SLAVES*AHB_ADDR_WIDTH-1:0]  END_ADDR_i,
    output logic                                 timeout_o
);

    localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

    // Data-phase owner. The default slave's error FSM is folded in: ERR1/ERR2
    // are the two DEF cycles, and the load cycle acts as the FSM's IDLE state.
    typedef enum logic [1:0] {
        ST_NONE,
        ST_SLV,
        ST_ERR1,
        ST_ERR2
    } own_state_e;

    own_state_e             state;
    logic [IDX_W-1:0]       owner_idx;
    logic [NB_SLAVES-1:0]   match;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_hit;
    logic                   wd_expire;

    // Range match per slave; END < START can never satisfy both compares.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        match = '0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            match[i] = hsel_i
                && (hadrr_i >= START_ADDR_i[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH])
                && (hadrr_i <= END_ADDR_i[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH]);
        end
    end

    // Priority encode: scan from the top so the lowest matching index wins.
    always_comb begin
        hsel_o  = '0;
        dec_idx = '0;
        dec_hit = 1'b0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hsel_o    = '0;
                hsel_o[i] = 1'b1;
                dec_idx   = IDX_W'(i);
                dec_hit   = 1'b1;
            end
        end
    end

    // Fan-out: the selected slave sees the master address phase, and the
    // data-phase owner sees write data. Every other slave sees zeros.
    always_comb begin
        hadrr_o     = '0;
        hwdata_o    = '0;
        hwrite_o    = '0;
        hmastlock_o = '0;
        htrans_o    = '0;
        hprot_o     = '0;
        hburst_o    = '0;
        hsize_o     = '0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (hsel_o[i]) begin
                hadrr_o[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH] = hadrr_i;
                hwrite_o[i]                                 = hwrite_i;
                hmastlock_o[i]                              = hmastlock_i;
                htrans_o[i*2 +: 2]                          = htrans_i;
                hprot_o[i*4 +: 4]                           = hprot_i;
                hburst_o[i*3 +: 3]                          = hburst_i;
                hsize_o[i*3 +: 3]                           = hsize_i;
            end
            if ((state == ST_SLV) && (owner_idx == IDX_W'(i))) begin
                hwdata_o[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH] = hwdata_i;
            end
        end
    end

    assign hready_o = {NB_SLAVES{hreadyout_o}};

    // Response mux driven by the registered data-phase owner.
    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        hrdata_o    = '0;
        case (state)
            ST_SLV: begin
                hreadyout_o = hreadyout_i[owner_idx];
                hresp_o     = hresp_i[owner_idx];
                hrdata_o    = hrdata_i[int'(owner_idx)*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
            end
            ST_ERR2: begin
                hresp_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Owner/error FSM. A new owner is captured only when the master sees ready.
    // After an ERROR the master normally drives IDLE, so this reload lands on NONE.
    always_ff @(posedge hclk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (hrst_i) begin
            state     <= ST_NONE;
            owner_idx <= '0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (hreadyout_o) begin
            if (dec_hit) begin
                state     <= ST_SLV;
                owner_idx <= dec_idx;
            end else if (hsel_i && htrans_i[1]) begin
                state <= ST_ERR1;
            end else begin
                state <= ST_NONE;
            end
        end else if (wd_expire) begin
            state <= ST_ERR1;
        end
    end

`ifdef AHB_LITE_NODE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Expire on the wait cycle whose increment would bring the count to TIMEOUT_CYCLES-1.
    assign wd_expire = (state == ST_SLV) && !hreadyout_i[owner_idx] && (wd_cnt == WD_LAST);

    // Wait-state counter; timeout_q marks the first cycle of the takeover ERROR.
    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if ((state == ST_SLV) && !hreadyout_i[owner_idx] && !wd_expire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    // Without the watchdog a stalled slave stalls the master indefinitely.
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_ahb_lite_node.sv
// Directed bench for ahb_lite_node with four slaves, each mapped to a 0x100 slot.
// Expected data-phase responses are queued as each address phase is driven.
// They are popped and compared on the falling edge of every cycle.
// The watchdog case follows the AHB_LITE_NODE_TIMEOUT_EN build setting.
module tb_ahb_lite_node;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic              hclk_i = 1'b0;
    logic              hrst_i;
    logic [AW-1:0]     hadrr_i;
    logic [DW-1:0]     hwdata_i;
    logic              hsel_i, hwrite_i, hmastlock_i;
    logic [1:0]        htrans_i;
    logic [3:0]        hprot_i;
    logic [2:0]        hburst_i, hsize_i;
    logic              hresp_o, hreadyout_o;
    logic [DW-1:0]     hrdata_o;
    logic [NB*AW-1:0]  hadrr_o;
    logic [NB*DW-1:0]  hwdata_o;
    logic [NB-1:0]     hsel_o, hwrite_o, hmastlock_o, hready_o;
    logic [NB*2-1:0]   htrans_o;
    logic [NB*4-1:0]   hprot_o;
    logic [NB*3-1:0]   hburst_o, hsize_o;
    logic [NB-1:0]     hresp_i, hreadyout_i;
    logic [NB*DW-1:0]  hrdata_i;
    logic [NB*AW-1:0]  START_ADDR_i, END_ADDR_i;
    logic              timeout_o;

    logic [DW-1:0]     s_rdata [NB];

    typedef struct {
        string         tag;
        logic          rdy;
        logic          resp;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 hclk_i = ~hclk_i;

    assign hrdata_i = {s_rdata[3], s_rdata[2], s_rdata[1], s_rdata[0]};

    ahb_lite_node #(
        .NB_SLAVES(NB), .AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .hclk_i(hclk_i), .hrst_i(hrst_i),
        .hadrr_i(hadrr_i), .hwdata_i(hwdata_i), .hsel_i(hsel_i),
        .hwrite_i(hwrite_i), .hmastlock_i(hmastlock_i),
        .htrans_i(htrans_i), .hprot_i(hprot_i), .hburst_i(hburst_i), .hsize_i(hsize_i),
        .hresp_o(hresp_o), .hreadyout_o(hreadyout_o), .hrdata_o(hrdata_o),
        .hadrr_o(hadrr_o), .hwdata_o(hwdata_o), .hsel_o(hsel_o),
        .hwrite_o(hwrite_o), .hmastlock_o(hmastlock_o), .hready_o(hready_o),
        .htrans_o(htrans_o), .hprot_o(hprot_o), .hburst_o(hburst_o), .hsize_o(hsize_o),
        .hresp_i(hresp_i), .hreadyout_i(hreadyout_i), .hrdata_i(hrdata_i),
        .START_ADDR_i(START_ADDR_i), .END_ADDR_i(END_ADDR_i),
        .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input string tag, input logic rdy, input logic resp,
                              input logic [DW-1:0] rdata);
        exp_t e;
        e.tag   = tag;
        e.rdy   = rdy;
        e.resp  = resp;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Falling edge of the current cycle: pop one expectation and compare it.
    task automatic at_neg();
        exp_t e;
        @(negedge hclk_i);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_ready"}, 32'(hreadyout_o), 32'(e.rdy));
            chk({e.tag, "_resp"},  32'(hresp_o),     32'(e.resp));
            chk({e.tag, "_rdata"}, hrdata_o,         e.rdata);
        end
    endtask

    task automatic to_next();
        @(posedge hclk_i);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        to_next();
    endtask

    task automatic master(input logic sel, input logic [AW-1:0] addr,
                          input logic [1:0] trans, input logic wr);
        hsel_i   = sel;
        hadrr_i  = addr;
        htrans_i = trans;
        hwrite_i = wr;
    endtask

    task automatic idle();
        master(1'b0, '0, T_IDLE, 1'b0);
    endtask

    task automatic set_slave(input int i, input logic rdy, input logic resp,
                             input logic [DW-1:0] rdata);
        hreadyout_i[i] = rdy;
        hresp_i[i]     = resp;
        s_rdata[i]     = rdata;
    endtask

    task automatic set_range(input int i, input logic [AW-1:0] s, input logic [AW-1:0] e);
        START_ADDR_i[i*AW +: AW] = s;
        END_ADDR_i[i*AW +: AW]   = e;
    endtask

    task automatic default_map();
        for (int i = 0; i < NB; i++) begin
            set_range(i, AW'(i * 'h100), AW'(i * 'h100 + 'hFF));
        end
    endtask

    initial begin
        // ---- reset ----
        hrst_i      = 1'b1;
        idle();
        hwdata_i    = '0;
        hmastlock_i = 1'b0;
        hprot_i     = 4'b0011;
        hburst_i    = 3'b000;
        hsize_i     = 3'b010;
        set_slave(0, 1'b1, 1'b0, 32'h0000_0A0A);
        set_slave(1, 1'b1, 1'b0, 32'h0000_0001);
        set_slave(2, 1'b1, 1'b0, 32'h0000_2222);
        set_slave(3, 1'b1, 1'b0, 32'h0000_3333);
        default_map();
        to_next();
        expect_rsp("reset", 1'b1, 1'b0, '0);
        at_neg();
        chk("reset_timeout", 32'(timeout_o), 32'd0);
        to_next();
        hrst_i = 1'b0;

        // ---- 1: NONSEQ read to slave 1 ----
        master(1'b1, 32'h1F0, T_NONSEQ, 1'b0);
        expect_rsp("t1_addr", 1'b1, 1'b0, '0);
        at_neg();
        chk("t1_hsel",      32'(hsel_o), 32'b0010);
        chk("t1_haddr1",    hadrr_o[1*AW +: AW], 32'h1F0);
        chk("t1_haddr0",    hadrr_o[0*AW +: AW], 32'h0);
        chk("t1_htrans1",   32'(htrans_o[1*2 +: 2]), 32'(T_NONSEQ));
        chk("t1_hprot1",    32'(hprot_o[1*4 +: 4]), 32'b0011);
        chk("t1_hready_all", 32'(hready_o), 32'hF);
        to_next();
        idle();
        set_slave(1, 1'b1, 1'b0, 32'hCAFE);
        expect_rsp("t1_data", 1'b1, 1'b0, 32'hCAFE);
        cyc();

        // ---- 2: unmapped NONSEQ -> two-cycle ERROR; unmapped IDLE -> OKAY ----
        master(1'b1, 32'h9000, T_NONSEQ, 1'b1);
        expect_rsp("t2_addr", 1'b1, 1'b0, '0);
        at_neg();
        chk("t2_hsel", 32'(hsel_o), 32'b0000);
        to_next();
        idle();
        expect_rsp("t2_err1", 1'b0, 1'b1, '0);
        cyc();
        expect_rsp("t2_err2", 1'b1, 1'b1, '0);
        cyc();
        master(1'b1, 32'h9000, T_IDLE, 1'b0);
        expect_rsp("t2_idle_addr", 1'b1, 1'b0, '0);
        cyc();
        idle();
        expect_rsp("t2_idle_data", 1'b1, 1'b0, '0);
        cyc();

        // ---- 3: overlapping ranges, lower index wins ----
        set_range(0, 32'h0, 32'hFFF);
        set_range(2, 32'h800, 32'h8FF);
        master(1'b1, 32'h850, T_NONSEQ, 1'b0);
        expect_rsp("t3_addr", 1'b1, 1'b0, '0);
        at_neg();
        chk("t3_hsel",   32'(hsel_o), 32'b0001);
        chk("t3_haddr2", hadrr_o[2*AW +: AW], 32'h0);
        to_next();
        idle();
        expect_rsp("t3_data", 1'b1, 1'b0, 32'h0A0A);
        cyc();
        default_map();

        // ---- boundaries: inverted range, START/END edges, address 0 and all-ones ----
        set_range(3, 32'h3FF, 32'h300);
        master(1'b1, 32'h350, T_IDLE, 1'b0);
        expect_rsp("b_inv", 1'b1, 1'b0, '0);
        at_neg();
        chk("b_inv_hsel", 32'(hsel_o), 32'b0000);
        to_next();
        master(1'b1, 32'h200, T_NONSEQ, 1'b0);
        expect_rsp("b_start", 1'b1, 1'b0, '0);
        at_neg();
        chk("b_start_hsel", 32'(hsel_o), 32'b0100);
        to_next();
        master(1'b1, 32'h2FF, T_NONSEQ, 1'b0);
        expect_rsp("b_end", 1'b1, 1'b0, 32'h2222);
        at_neg();
        chk("b_end_hsel", 32'(hsel_o), 32'b0100);
        to_next();
        set_range(3, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        master(1'b1, 32'hFFFF_FFFF, T_NONSEQ, 1'b0);
        expect_rsp("b_ones", 1'b1, 1'b0, 32'h2222);
        at_neg();
        chk("b_ones_hsel", 32'(hsel_o), 32'b1000);
        to_next();
        master(1'b1, 32'h0, T_NONSEQ, 1'b0);
        expect_rsp("b_zero", 1'b1, 1'b0, 32'h3333);
        at_neg();
        chk("b_zero_hsel", 32'(hsel_o), 32'b0001);
        to_next();
        idle();
        expect_rsp("b_zero_data", 1'b1, 1'b0, 32'h0A0A);
        cyc();
        default_map();

        // ---- 4: slave 1 stalls with next address to slave 3; slave 3 forwards ERROR ----
        master(1'b1, 32'h1F0, T_NONSEQ, 1'b1);
        expect_rsp("t4_a1", 1'b1, 1'b0, '0);
        at_neg();
        chk("t4_hwrite", 32'(hwrite_o), 32'b0010);
        to_next();
        master(1'b1, 32'h310, T_NONSEQ, 1'b0);
        hwdata_i = 32'h1234_5678;
        set_slave(1, 1'b0, 1'b0, 32'h1);
        for (int k = 0; k < 3; k++) begin
            expect_rsp("t4_stall", 1'b0, 1'b0, 32'h1);
            at_neg();
            chk("t4_stall_hsel", 32'(hsel_o), 32'b1000);
            chk("t4_hwdata1", hwdata_o[1*DW +: DW], 32'h1234_5678);
            chk("t4_hwdata3", hwdata_o[3*DW +: DW], 32'h0);
            to_next();
        end
        set_slave(1, 1'b1, 1'b0, 32'h1);
        expect_rsp("t4_s1_done", 1'b1, 1'b0, 32'h1);
        cyc();
        idle();
        hwdata_i = '0;
        set_slave(1, 1'b1, 1'b0, 32'hCAFE);
        set_slave(3, 1'b0, 1'b1, 32'h3333);
        expect_rsp("t4_s3_err1", 1'b0, 1'b1, 32'h3333);
        cyc();
        set_slave(3, 1'b1, 1'b1, 32'h3333);
        expect_rsp("t4_s3_err2", 1'b1, 1'b1, 32'h3333);
        cyc();
        set_slave(3, 1'b1, 1'b0, 32'h3333);
        expect_rsp("t4_after", 1'b1, 1'b0, '0);
        cyc();

        // ---- 5: slave 0 stalls ----
        master(1'b1, 32'h010, T_NONSEQ, 1'b0);
        expect_rsp("t5_addr", 1'b1, 1'b0, '0);
        cyc();
        idle();
        set_slave(0, 1'b0, 1'b0, 32'h0A0A);
`ifdef AHB_LITE_NODE_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            expect_rsp("t5_wait", 1'b0, 1'b0, 32'h0A0A);
            at_neg();
            chk("t5_no_pulse", 32'(timeout_o), 32'd0);
            to_next();
        end
        expect_rsp("t5_err1", 1'b0, 1'b1, '0);
        at_neg();
        chk("t5_pulse", 32'(timeout_o), 32'd1);
        to_next();
        expect_rsp("t5_err2", 1'b1, 1'b1, '0);
        at_neg();
        chk("t5_pulse_end", 32'(timeout_o), 32'd0);
        to_next();
        master(1'b1, 32'h1F0, T_NONSEQ, 1'b0);
        expect_rsp("t5_next_addr", 1'b1, 1'b0, '0);
        cyc();
        idle();
        expect_rsp("t5_next_data", 1'b1, 1'b0, 32'hCAFE);
        cyc();
        set_slave(0, 1'b1, 1'b0, 32'h0A0A);
`else
        for (int k = 0; k < 10; k++) begin
            expect_rsp("t5_stall", 1'b0, 1'b0, 32'h0A0A);
            at_neg();
            chk("t5_no_timeout", 32'(timeout_o), 32'd0);
            to_next();
        end
        set_slave(0, 1'b1, 1'b0, 32'h0A0A);
        expect_rsp("t5_release", 1'b1, 1'b0, 32'h0A0A);
        cyc();
`endif

        // ---- 6: reset during default-slave ERR1 drops the data phase ----
        master(1'b1, 32'h9000, T_NONSEQ, 1'b0);
        expect_rsp("t6_addr", 1'b1, 1'b0, '0);
        cyc();
        idle();
        hrst_i = 1'b1;
        expect_rsp("t6_err1", 1'b0, 1'b1, '0);
        cyc();
        hrst_i = 1'b0;
        expect_rsp("t6_after_rst", 1'b1, 1'b0, '0);
        cyc();
        expect_rsp("t6_still_none", 1'b1, 1'b0, '0);
        cyc();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
